// File: rtl/mirfak_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Optional macro MIRFAK_DIV_EARLY_OUT_EN: divide-by-zero and signed MIN/-1 finish without iterating.
module mirfak_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             div_valid_i,
  input  logic [1:0]       div_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             exwb_enable_i,
  input  logic             kill_i,
  output logic             ex_busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: an op is accepted in IDLE when div_valid_i is high and kill_i is low;
  // result_valid_o stays high in DONE until exwb_enable_i (or a dropped div_valid_i) releases it.

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] q_q, r_q, b_q, result_q;
  logic             negq_q, negr_q, is_rem_q;
  logic             busy, start, last;

  logic             op_signed, a_neg, b_neg, negq_new;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   r_shift;
  logic             take;
  logic [WIDTH-1:0] r_next, q_next, quo_fix, rem_fix, res_next;
  logic             early_hit;
  logic [WIDTH-1:0] early_res;

  assign op_signed = ~div_op_i[0];
  assign a_neg     = op_signed & dividend_i[WIDTH-1];
  assign b_neg     = op_signed & divisor_i[WIDTH-1];
  assign a_abs     = a_neg ? -dividend_i : dividend_i;
  assign b_abs     = b_neg ? -divisor_i : divisor_i;
  // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
  assign negq_new  = (a_neg ^ b_neg) & (|divisor_i);

  assign r_shift  = {r_q, q_q[WIDTH-1]};
  assign take     = (r_shift >= {1'b0, b_q});
  assign r_next   = take ? (r_shift[WIDTH-1:0] - b_q) : r_shift[WIDTH-1:0];
  assign q_next   = {q_q[WIDTH-2:0], take};
  assign quo_fix  = negq_q ? -q_next : q_next;
  assign rem_fix  = negr_q ? -r_next : r_next;
  assign res_next = is_rem_q ? rem_fix : quo_fix;
  assign last     = (count_q == CW'(WIDTH - 1));

`ifdef MIRFAK_DIV_EARLY_OUT_EN
  logic div_zero, div_ovf;
  assign div_zero  = (divisor_i == '0);
  assign div_ovf   = op_signed & (dividend_i == MIN_VAL) & (&divisor_i);
  assign early_hit = div_zero | div_ovf;
  assign early_res = div_zero ? (div_op_i[1] ? dividend_i : '1)
                              : (div_op_i[1] ? '0 : MIN_VAL);
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = div_valid_i & ~kill_i;
        if (busy) state_d = early_hit ? DONE : CALC;
      end
      CALC: begin
        busy = ~kill_i;
        if (kill_i)    state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        if (kill_i | exwb_enable_i | ~div_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start          = (state_q == IDLE) & div_valid_i & ~kill_i;
  // Busy is gated by reset so an asserted reset silences the stall request at once.
  assign ex_busy_o      = busy & rst_ni;
  assign result_o       = result_q;
  assign result_valid_o = (state_q == DONE) & ~kill_i;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      q_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            q_q      <= a_abs;
            b_q      <= b_abs;
            r_q      <= '0;
            count_q  <= '0;
            negq_q   <= negq_new;
            negr_q   <= a_neg;
            is_rem_q <= div_op_i[1];
            if (early_hit) result_q <= early_res;
          end
        end
        CALC: begin
          if (!kill_i) begin
            q_q     <= q_next;
            r_q     <= r_next;
            count_q <= count_q + 1'b1;
            if (last) result_q <= res_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mirfak_div_unit.sv
// Self-checking bench for mirfak_div_unit: directed RV32M corner cases plus random ops
// against an arithmetic reference model.
module tb_mirfak_div_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         div_valid, exwb_enable, kill;
  logic [1:0]   div_op;
  logic [W-1:0] dividend, divisor;
  logic         ex_busy, result_valid;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  mirfak_div_unit #(.WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .div_valid_i    (div_valid),
    .div_op_i       (div_op),
    .dividend_i     (dividend),
    .divisor_i      (divisor),
    .exwb_enable_i  (exwb_enable),
    .kill_i         (kill),
    .ex_busy_o      (ex_busy),
    .result_o       (result),
    .result_valid_o (result_valid),
    .dbg_state_o    (dbg_state)
  );

  // reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, r;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    r = op[1] ? (sa % sb) : (sa / sb);
    return r[W-1:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    bit corner;
    bit early;
    corner = (b == '0) || (!op[0] && a == MIN_VAL && b == '1);
    early  = 1'b0;
`ifdef MIRFAK_DIV_EARLY_OUT_EN
    early  = 1'b1;
`endif
    return (early && corner) ? 1 : W + 1;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: issue one op, count busy cycles, check result, then hold DONE for 'stall' cycles
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input string tag);
    int cyc, busy_cnt, lat;
    logic [W-1:0] exp;
    exp_q.push_back(ref_div(op, a, b));
    lat = exp_lat(op, a, b);
    div_valid = 1'b1; div_op = op; dividend = a; divisor = b;
    exwb_enable = 1'b0; kill = 1'b0;
    cyc = 0; busy_cnt = 0;
    #1;
    while (!result_valid && cyc < 200) begin
      if (ex_busy) busy_cnt++;
      @(posedge clk); #1;
      dividend = $urandom;
      divisor  = $urandom;
      cyc++;
    end
    chk({tag, " latency"}, W'(cyc), W'(lat));
    chk({tag, " busy"}, W'(busy_cnt), W'(lat));
    exp = exp_q.pop_front();
    chk({tag, " result"}, result, exp);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, " stall valid"}, W'(result_valid), W'(1));
      chk({tag, " stall result"}, result, exp);
      chk({tag, " stall busy"}, W'(ex_busy), W'(0));
    end
  endtask

  task automatic release_op(input logic keep_valid);
    exwb_enable = 1'b1;
    @(posedge clk); #1;
    exwb_enable = 1'b0;
    if (!keep_valid) div_valid = 1'b0;
    chk("release valid", W'(result_valid), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           sel;

    rst_n = 1'b0; div_valid = 1'b0; div_op = '0; dividend = '0; divisor = '0;
    exwb_enable = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", W'(ex_busy), W'(0));
    chk("reset result", result, '0);
    chk("reset valid", W'(result_valid), W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op(2'b01, 32'd100, 32'd7, 0, "divu 100/7");         release_op(1'b1);
    run_op(2'b11, 32'd100, 32'd7, 5, "remu 100/7 stall");   release_op(1'b1);
    run_op(2'b00, -32'sd7, 32'd2, 0, "div -7/2");           release_op(1'b1);
    run_op(2'b10, -32'sd7, 32'd2, 0, "rem -7/2");           release_op(1'b1);
    run_op(2'b00, MIN_VAL, '1, 0, "div min/-1");            release_op(1'b1);
    run_op(2'b10, MIN_VAL, '1, 0, "rem min/-1");            release_op(1'b1);
    run_op(2'b01, 32'd5, 32'd0, 0, "divu 5/0");             release_op(1'b1);
    run_op(2'b11, 32'd5, 32'd0, 0, "remu 5/0");             release_op(1'b1);
    run_op(2'b00, -32'sd5, 32'd0, 0, "div -5/0");           release_op(1'b1);
    run_op(2'b10, -32'sd5, 32'd0, 1, "rem -5/0");           release_op(1'b0);

    // kill at CALC count 10, then a fresh op must take the full latency
    div_valid = 1'b1; div_op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    kill = 1'b1;
    #1;
    chk("kill busy", W'(ex_busy), W'(0));
    chk("kill valid", W'(result_valid), W'(0));
    @(posedge clk); #1;
    kill = 1'b0;
    run_op(2'b01, 32'd9, 32'd3, 0, "divu 9/3 after kill");

    // kill while DONE drops the result
    kill = 1'b1;
    #1;
    chk("kill done valid", W'(result_valid), W'(0));
    chk("kill done busy", W'(ex_busy), W'(0));
    div_valid = 1'b0;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("post kill valid", W'(result_valid), W'(0));

    // reset mid-CALC
    div_valid = 1'b1; div_op = 2'b01; dividend = 32'd77; divisor = 32'd4;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", W'(ex_busy), W'(0));
    chk("midreset valid", W'(result_valid), W'(0));
    chk("midreset result", result, '0);
    repeat (2) @(posedge clk);
    #1;
    div_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after reset busy", W'(ex_busy), W'(0));
    run_op(2'b01, 32'd77, 32'd4, 0, "divu after reset");    release_op(1'b0);

    // random ops
    for (int n = 0; n < 14; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = '0;
        1:       begin ra = MIN_VAL; rb = '1; end
        2:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 3), "random");
      release_op(1'($urandom_range(0, 1)));
    end

    div_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
